// File: rtl/multi_token_reader_if.sv
// Channel bundle for multi_token_reader: producer-side VALID/CONSUMED data and
// enable channels, consumer-side VALID/ACCEPT head token, and statistics.
// master = surrounding logic (producer + consumer), slave = the reader.
interface multi_token_reader_if #(
  parameter int width = 1
);
  localparam int W = (width > 0) ? width : 1;

  logic [W-1:0] IN_READ;
  logic         IN_READ_VALID;
  logic         IN_READ_CONSUMED;
  logic         IN_EN;
  logic         IN_EN_VALID;
  logic         IN_EN_CONSUMED;
  logic [W-1:0] OUT_DATA;
  logic         OUT_EN;
  logic         OUT_VALID;
  logic         OUT_ACCEPT;
  logic [15:0]  TOKEN_COUNT;
  logic [15:0]  SKIP_COUNT;

  modport master (
    output IN_READ, IN_READ_VALID, IN_EN, IN_EN_VALID, OUT_ACCEPT,
    input  IN_READ_CONSUMED, IN_EN_CONSUMED, OUT_DATA, OUT_EN, OUT_VALID,
           TOKEN_COUNT, SKIP_COUNT
  );

  modport slave (
    input  IN_READ, IN_READ_VALID, IN_EN, IN_EN_VALID, OUT_ACCEPT,
    output IN_READ_CONSUMED, IN_EN_CONSUMED, OUT_DATA, OUT_EN, OUT_VALID,
           TOKEN_COUNT, SKIP_COUNT
  );
endinterface

// File: rtl/multi_token_reader.sv
// multi_token_reader: joins a data channel and an enable channel into one
// token, buffers it in a 2-entry FIFO and presents it through VALID/ACCEPT.
// Optional macro MULTI_TOKEN_READER_BYPASS_EN: when the FIFO is empty, an
// incoming stored token is presented combinationally in the same cycle.
module multi_token_reader #(
  parameter int width         = 1,
  parameter int SKIP_DISABLED = 0
) (
  input logic                 CLK,
  input logic                 RST_N,
  multi_token_reader_if.slave bus
);

  localparam int W = (width > 0) ? width : 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e       state_q;
  logic         valid_q;
  logic [W-1:0] head_data_q;
  logic         head_en_q;
  logic [W-1:0] tail_data_q;
  logic         tail_en_q;
  logic [15:0]  token_cnt_q;
  logic [15:0]  skip_cnt_q;

  logic         inp_valid;
  logic         in_fire;
  logic         store;
  logic         out_fire;
  logic         out_valid;
  logic         out_en;
  logic [W-1:0] out_data;
  logic [W-1:0] in_data;
  logic         skip_en;

  // Without a data channel the stored data is tied to zero.
  if (width == 0) begin : g_no_data
    assign in_data   = '0;
    assign inp_valid = bus.IN_EN_VALID;
  end else begin : g_data
    assign in_data   = bus.IN_READ;
    assign inp_valid = bus.IN_READ_VALID && bus.IN_EN_VALID;
  end

  assign skip_en  = (SKIP_DISABLED != 0);
  assign in_fire  = inp_valid && (state_q != FULL);
  assign store    = in_fire && !(skip_en && !bus.IN_EN);
  assign out_fire = out_valid && bus.OUT_ACCEPT;

  // Both channels are consumed together; never during reset, never from ACCEPT.
  assign bus.IN_READ_CONSUMED = in_fire && RST_N;
  assign bus.IN_EN_CONSUMED   = in_fire && RST_N;

  // Head token presentation, with optional same-cycle bypass when empty.
  always_comb begin
    out_valid = valid_q;
    out_data  = head_data_q;
    out_en    = head_en_q;
`ifdef MULTI_TOKEN_READER_BYPASS_EN
    if ((state_q == EMPTY) && store) begin
      out_valid = 1'b1;
      out_data  = in_data;
      out_en    = bus.IN_EN;
    end
`endif
  end

  assign bus.OUT_VALID   = out_valid;
  assign bus.OUT_DATA    = out_data;
  assign bus.OUT_EN      = out_en;
  assign bus.TOKEN_COUNT = token_cnt_q;
  assign bus.SKIP_COUNT  = skip_cnt_q;

  // Occupancy FSM, FIFO storage and per-token statistics.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= EMPTY;
      valid_q     <= 1'b0;
      head_data_q <= '0;
      head_en_q   <= 1'b0;
      tail_data_q <= '0;
      tail_en_q   <= 1'b0;
      token_cnt_q <= '0;
      skip_cnt_q  <= '0;
    end else begin
      if (in_fire) begin
        token_cnt_q <= token_cnt_q + 16'd1;
      end
      if (in_fire && !store) begin
        skip_cnt_q <= skip_cnt_q + 16'd1;
      end
      case (state_q)
        EMPTY: begin
          // out_fire here is only possible via bypass: token delivered, stay empty
          if (store) begin
            head_data_q <= in_data;
            head_en_q   <= bus.IN_EN;
            if (!out_fire) begin
              state_q <= ONE;
              valid_q <= 1'b1;
            end
          end
        end
        ONE: begin
          if (store && out_fire) begin
            head_data_q <= in_data;
            head_en_q   <= bus.IN_EN;
          end else if (store) begin
            tail_data_q <= in_data;
            tail_en_q   <= bus.IN_EN;
            state_q     <= FULL;
          end else if (out_fire) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            head_data_q <= tail_data_q;
            head_en_q   <= tail_en_q;
            state_q     <= ONE;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_token_reader.sv
// Directed bench for multi_token_reader: two instances (SKIP_DISABLED=0 and 1)
// driven by the same stimulus, each checked against hand-computed values.
module tb_multi_token_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rd;
  logic       rd_v;
  logic       en;
  logic       en_v;
  logic       acc;

  int n_vec = 0;
  int n_err = 0;

  multi_token_reader_if #(.width(8)) b0 ();
  multi_token_reader_if #(.width(8)) b1 ();

  assign b0.IN_READ       = rd;
  assign b0.IN_READ_VALID = rd_v;
  assign b0.IN_EN         = en;
  assign b0.IN_EN_VALID   = en_v;
  assign b0.OUT_ACCEPT    = acc;
  assign b1.IN_READ       = rd;
  assign b1.IN_READ_VALID = rd_v;
  assign b1.IN_EN         = en;
  assign b1.IN_EN_VALID   = en_v;
  assign b1.OUT_ACCEPT    = acc;

  multi_token_reader #(.width(8), .SKIP_DISABLED(0)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .bus(b0)
  );
  multi_token_reader #(.width(8), .SKIP_DISABLED(1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .bus(b1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_v = 1'b0;
    en_v = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rd = '0; rd_v = 1'b0; en = 1'b0; en_v = 1'b0; acc = 1'b0;
    step();
    step();
    // reset state
    check("rst_valid",  {31'd0, b0.OUT_VALID}, 32'd0);
    check("rst_data",   {24'd0, b0.OUT_DATA},  32'd0);
    check("rst_en",     {31'd0, b0.OUT_EN},    32'd0);
    check("rst_tokcnt", {16'd0, b0.TOKEN_COUNT}, 32'd0);
    rst_n = 1'b1;

    // 1: single token, consumer accepting
    rd = 8'h01; en = 1'b1; rd_v = 1'b1; en_v = 1'b1; acc = 1'b1;
    #1;
    check("t1_rd_cons", {31'd0, b0.IN_READ_CONSUMED}, 32'd1);
    check("t1_en_cons", {31'd0, b0.IN_EN_CONSUMED},   32'd1);
`ifdef MULTI_TOKEN_READER_BYPASS_EN
    check("t1_byp_valid", {31'd0, b0.OUT_VALID}, 32'd1);
    check("t1_byp_data",  {24'd0, b0.OUT_DATA},  32'h01);
`else
    check("t1_pre_valid", {31'd0, b0.OUT_VALID}, 32'd0);
`endif
    step();
    idle_inputs();
    #1;
`ifdef MULTI_TOKEN_READER_BYPASS_EN
    check("t1_valid", {31'd0, b0.OUT_VALID}, 32'd0);
`else
    check("t1_valid", {31'd0, b0.OUT_VALID}, 32'd1);
    check("t1_data",  {24'd0, b0.OUT_DATA},  32'h01);
    check("t1_en",    {31'd0, b0.OUT_EN},    32'd1);
`endif
    check("t1_tokcnt", {16'd0, b0.TOKEN_COUNT}, 32'd1);
    step();
    check("t1_drained", {31'd0, b0.OUT_VALID}, 32'd0);

    // 2: three tokens with consumer stalled, then drained in order
    acc = 1'b0; rd_v = 1'b1; en_v = 1'b1; en = 1'b1;
    rd = 8'h01; #1;
    check("t2_cons1", {31'd0, b0.IN_READ_CONSUMED}, 32'd1);
    step();
    rd = 8'h02; #1;
    check("t2_cons2", {31'd0, b0.IN_READ_CONSUMED}, 32'd1);
    step();
    rd = 8'h03; #1;
    check("t2_full_rd", {31'd0, b0.IN_READ_CONSUMED}, 32'd0);
    check("t2_full_en", {31'd0, b0.IN_EN_CONSUMED},   32'd0);
    check("t2_head1",   {24'd0, b0.OUT_DATA}, 32'h01);
    step();
    check("t2_hold1", {24'd0, b0.OUT_DATA}, 32'h01);
    acc = 1'b1; #1;
    check("t2_full_acc", {31'd0, b0.IN_READ_CONSUMED}, 32'd0);
    step();
    check("t2_head2", {24'd0, b0.OUT_DATA}, 32'h02);
    check("t2_cons3", {31'd0, b0.IN_READ_CONSUMED}, 32'd1);
    step();
    idle_inputs(); #1;
    check("t2_head3",  {24'd0, b0.OUT_DATA},  32'h03);
    check("t2_valid3", {31'd0, b0.OUT_VALID}, 32'd1);
    step();
    check("t2_empty",  {31'd0, b0.OUT_VALID}, 32'd0);
    check("t2_tokcnt", {16'd0, b0.TOKEN_COUNT}, 32'd4);

    // 3: data channel valid alone is never consumed
    rd = 8'h07; rd_v = 1'b1; en_v = 1'b0; #1;
    check("t3_rd_cons", {31'd0, b0.IN_READ_CONSUMED}, 32'd0);
    check("t3_en_cons", {31'd0, b0.IN_EN_CONSUMED},   32'd0);
    step();
    check("t3_valid",  {31'd0, b0.OUT_VALID}, 32'd0);
    check("t3_tokcnt", {16'd0, b0.TOKEN_COUNT}, 32'd4);
    idle_inputs();

    // 4: disabled token skipped by the SKIP_DISABLED instance
    do_reset();
    acc = 1'b1; rd = 8'h05; en = 1'b0; rd_v = 1'b1; en_v = 1'b1; #1;
    check("t4_skip_cons", {31'd0, b1.IN_EN_CONSUMED}, 32'd1);
    step();
    idle_inputs(); #1;
    check("t4_skip_hidden", {31'd0, b1.OUT_VALID}, 32'd0);
    acc = 1'b0; rd = 8'h06; en = 1'b1; rd_v = 1'b1; en_v = 1'b1;
    step();
    idle_inputs(); #1;
    check("t4_valid",   {31'd0, b1.OUT_VALID}, 32'd1);
    check("t4_data",    {24'd0, b1.OUT_DATA},  32'h06);
    check("t4_en",      {31'd0, b1.OUT_EN},    32'd1);
    check("t4_tokcnt",  {16'd0, b1.TOKEN_COUNT}, 32'd2);
    check("t4_skipcnt", {16'd0, b1.SKIP_COUNT},  32'd1);
    check("t4_tokcnt0", {16'd0, b0.TOKEN_COUNT}, 32'd2);
    check("t4_skipcnt0",{16'd0, b0.SKIP_COUNT},  32'd0);
    acc = 1'b1;
    step(); step(); step();
    check("t4_drain0", {31'd0, b0.OUT_VALID}, 32'd0);
    check("t4_drain1", {31'd0, b1.OUT_VALID}, 32'd0);

    // 5: reset while full with inputs valid
    acc = 1'b0; en = 1'b1; rd_v = 1'b1; en_v = 1'b1;
    rd = 8'h0A; step();
    rd = 8'h0B; step();
    rd = 8'h0C; #1;
    check("t5_full", {31'd0, b0.IN_READ_CONSUMED}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_cons0", {30'd0, b0.IN_READ_CONSUMED, b0.IN_EN_CONSUMED}, 32'd0);
    check("t5_rst_cons1", {30'd0, b1.IN_READ_CONSUMED, b1.IN_EN_CONSUMED}, 32'd0);
    step();
    rst_n = 1'b1;
    idle_inputs(); #1;
    check("t5_valid0",  {31'd0, b0.OUT_VALID},   32'd0);
    check("t5_data0",   {24'd0, b0.OUT_DATA},    32'd0);
    check("t5_tokcnt0", {16'd0, b0.TOKEN_COUNT}, 32'd0);
    check("t5_skipcnt1",{16'd0, b1.SKIP_COUNT},  32'd0);
    check("t5_tokcnt1", {16'd0, b1.TOKEN_COUNT}, 32'd0);

    // 6: sustained stream of 0x10000 tokens, counter wrap
    acc = 1'b1; en = 1'b1; rd_v = 1'b1; en_v = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      rd = 8'h5A ^ i[7:0];
      if (i == 0) begin
        #1;
        check("t6_first_cons", {31'd0, b0.IN_READ_CONSUMED}, 32'd1);
`ifdef MULTI_TOKEN_READER_BYPASS_EN
        check("t6_byp_data", {24'd0, b0.OUT_DATA}, 32'h5A);
`endif
      end
      if (i == 2) begin
        #1;
        check("t6_stream_cons", {31'd0, b0.IN_READ_CONSUMED}, 32'd1);
`ifndef MULTI_TOKEN_READER_BYPASS_EN
        check("t6_stream_data", {24'd0, b0.OUT_DATA}, 32'h5B);
`endif
      end
      if (i == 65535) begin
        #1;
        check("t6_tokcnt_max", {16'd0, b0.TOKEN_COUNT}, 32'hFFFF);
      end
      step();
    end
    idle_inputs(); #1;
    check("t6_wrap0", {16'd0, b0.TOKEN_COUNT}, 32'd0);
    check("t6_wrap1", {16'd0, b1.TOKEN_COUNT}, 32'd0);
    check("t6_skip1", {16'd0, b1.SKIP_COUNT},  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_token_reader.md
Name: multi_token_reader

Overview:
- Consumer endpoint of the multi-cycle VALID/CONSUMED token channel protocol used by the multi-domain primitives (wire/pulse/reg).
- Joins a data channel and an enable channel into one token and holds it in a 2-entry FIFO.
- Presents tokens to a normal-domain consumer through a VALID/ACCEPT handshake and keeps per-token statistics.
- Sits between a multi-domain producer, such as a register read port, and plain synchronous logic.

Parameters:
- width, 1: data bits per token. 0 means no data channel: IN_READ is ignored and IN_READ_VALID is treated as 1.
- SKIP_DISABLED, 0: when 1, tokens with enable=0 are consumed upstream but never buffered or presented.

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset
- IN_READ  in  max(width,1)  token data from producer
- IN_READ_VALID  in  1  data channel valid
- IN_READ_CONSUMED  out  1  data channel consumed
- IN_EN  in  1  token enable bit
- IN_EN_VALID  in  1  enable channel valid
- IN_EN_CONSUMED  out  1  enable channel consumed
- OUT_DATA  out  max(width,1)  head token data
- OUT_EN  out  1  head token enable
- OUT_VALID  out  1  head token present
- OUT_ACCEPT  in  1  consumer takes head token this cycle
- TOKEN_COUNT  out  16  tokens consumed upstream, including skipped tokens
- SKIP_COUNT  out  16  tokens dropped by SKIP_DISABLED

Reset: RST_N, synchronous, active-low; clock CLK.

Behaviour:
- inpValid = (width==0 ? 1 : IN_READ_VALID) && IN_EN_VALID.
- Occupancy states: EMPTY (0 entries), ONE (1), FULL (2).
- IN_READ_CONSUMED = IN_EN_CONSUMED = inpValid && state!=FULL && RST_N.
  - Both channels are always consumed together, never one alone.
  - There is no combinational path from OUT_ACCEPT to the CONSUMED outputs.
- in_fire = inpValid && state!=FULL.
- store = in_fire && !(SKIP_DISABLED && !IN_EN).
- out_fire = OUT_VALID && OUT_ACCEPT.
- State transitions:
  - EMPTY: store -> ONE; otherwise stay.
  - ONE: store && !out_fire -> FULL; !store && out_fire -> EMPTY; both or neither -> ONE. When both, the new token becomes head next cycle.
  - FULL: out_fire -> ONE (tail moves to head); store is impossible because CONSUMED=0.
- FULL blocks enqueue even when out_fire occurs in the same cycle. Throughput therefore matches the producer-side register: 1 token/cycle sustained with state ONE.
- Latency: a token consumed at edge N is visible on OUT_VALID/OUT_DATA/OUT_EN after edge N (registered, 1 cycle).
- Ordering: strict FIFO.
- OUT_DATA and OUT_EN hold their value while OUT_VALID=1 and OUT_ACCEPT=0.
- OUT_DATA and OUT_EN are don't-care when OUT_VALID=0; implementation holds the last value.
- Counters:
  - TOKEN_COUNT increments on every in_fire.
  - SKIP_COUNT increments on in_fire && !store.
  - Both are 16-bit and wrap 0xFFFF -> 0x0000.
- Reset, synchronous at the edge with RST_N=0:
  - state EMPTY, OUT_VALID=0, OUT_DATA=0, OUT_EN=0, TOKEN_COUNT=0, SKIP_COUNT=0.
  - Buffered tokens are discarded.
  - CONSUMED outputs are 0 in every cycle RST_N=0, so no token is lost upstream during reset.
- width==0: OUT_DATA is constant 0; only the enable bit is stored.

Optional Feature:
- Macro: MULTI_TOKEN_READER_BYPASS_EN.
- Defined:
  - When state=EMPTY and in_fire with store, the incoming token drives OUT_DATA/OUT_EN/OUT_VALID combinationally in the same cycle.
  - If OUT_ACCEPT=1 that cycle, the token is delivered with 0 latency and state stays EMPTY. Otherwise it is written and state becomes ONE.
  - The CONSUMED outputs remain independent of OUT_ACCEPT.
- Not defined: all outputs are registered, with 1-cycle minimum latency as above.

Test Plan:
1. Reset, then IN_READ=0x1, IN_EN=1, both VALID for 1 cycle, OUT_ACCEPT=1 -> CONSUMED=1 that cycle; next cycle OUT_VALID=1, OUT_DATA=1, OUT_EN=1; TOKEN_COUNT=1.
2. OUT_ACCEPT=0, offer 3 tokens (data 1,2,3) back-to-back -> first two consumed, CONSUMED=0 on the third while FULL. Raise OUT_ACCEPT -> outputs 1,2,3 in order; third consumed the cycle after FULL->ONE.
3. IN_READ_VALID=1, IN_EN_VALID=0 -> both CONSUMED=0, no state change, TOKEN_COUNT unchanged.
4. SKIP_DISABLED=1, tokens (en=0,d=5), (en=1,d=6) -> only d=6 presented; TOKEN_COUNT=2, SKIP_COUNT=1.
5. FULL buffer, assert RST_N=0 for 1 cycle with inputs valid -> CONSUMED=0 during reset; afterwards OUT_VALID=0, counters 0.
6. Sustained 0x10000 tokens with OUT_ACCEPT=1 -> TOKEN_COUNT wraps to 0. With MULTI_TOKEN_READER_BYPASS_EN, first token appears on OUT_DATA in the same cycle it is consumed.
